// File: rtl/ahbl_pkg.sv
// rtl/ahbl_pkg.sv - shared AHB-lite codes and SRAM controller state encoding
package ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_RD_STALL,
        ST_ERR1,
        ST_ERR2
    } ctrl_state_e;

    function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
        bank_onehot = 4'b0001 << bank;
    endfunction

endpackage

// File: rtl/ahbl_lane_dec.sv
// rtl/ahbl_lane_dec.sv - {HSIZE, HADDR[1:0]} to byte-lane mask with illegal-transfer flag
module ahbl_lane_dec
    import ahbl_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] lanes,
    output logic       illegal
);

    // Illegal transfers report an empty mask so nothing downstream can write.
    always_comb begin
        lanes   = 4'b0000;
        illegal = 1'b0;
        case (hsize)
            HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                if (addr_lo[0]) begin
                    illegal = 1'b1;
                end else begin
                    lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
            end
            HSIZE_WORD: begin
                if (addr_lo != 2'b00) begin
                    illegal = 1'b1;
                end else begin
                    lanes = 4'b1111;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahbl_sram_ctrl.sv
// rtl/ahbl_sram_ctrl.sv - AHB-lite slave serving a four-bank single-port synchronous SRAM
module ahbl_sram_ctrl
    import ahbl_pkg::*;
#(
    parameter int AW     = 15,
    parameter int RD_LAT = 1
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [31:0]   SRAMRDATA,
    output logic [3:0]    SRAMWEN,
    output logic [31:0]   SRAMWDATA,
    output logic          SRAMCS0,
    output logic          SRAMCS1,
    output logic          SRAMCS2,
    output logic          SRAMCS3,
    output logic [AW-1:0] SRAMADDR
);

    if (RD_LAT != 1) begin : g_rd_lat_check
        $error("ahbl_sram_ctrl: only RD_LAT=1 is supported");
    end

    ctrl_state_e   state;
    logic [AW-1:0] lat_addr;
    logic [1:0]    lat_bank;
    logic [3:0]    lat_lanes;
    logic          hreadyout_q;
    logic          hresp_q;

    logic [3:0]    dec_lanes;
    logic          dec_illegal;
    logic          accept;
    logic          rd_issue;
    logic [AW-1:0] haddr_word;
    logic [1:0]    haddr_bank;
    logic [3:0]    sram_cs;
    logic          unused_bits;

    ahbl_lane_dec u_lane_dec (
        .hsize   (HSIZE),
        .addr_lo (HADDR[1:0]),
        .lanes   (dec_lanes),
        .illegal (dec_illegal)
    );

    assign accept     = HSEL & HTRANS[1] & HREADY;
    assign haddr_word = HADDR[AW+1:2];
    assign haddr_bank = HADDR[AW+3:AW+2];

    // A legal read goes straight to the SRAM unless a write owns the port this cycle.
    assign rd_issue = accept & ~dec_illegal & ~HWRITE &
                      ((state == ST_IDLE) | (state == ST_RD_DATA) | (state == ST_ERR2));

    // Upper address bits belong to the system decoder; HTRANS[0] only separates NONSEQ/SEQ.
    assign unused_bits = &{1'b0, HADDR[31:AW+4], HTRANS[0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= ST_IDLE;
            lat_addr    <= '0;
            lat_bank    <= 2'b00;
            lat_lanes   <= 4'b0000;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            case (state)
                ST_RD_STALL: begin
                    state       <= ST_RD_DATA;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    state       <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    if (accept) begin
                        if (dec_illegal) begin
                            state       <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else if (HWRITE) begin
                            state     <= ST_WR_DATA;
                            lat_addr  <= haddr_word;
                            lat_bank  <= haddr_bank;
                            lat_lanes <= dec_lanes;
                        end else if (state == ST_WR_DATA) begin
                            // Port is busy with the write: hold the read for one stall cycle.
                            state       <= ST_RD_STALL;
                            hreadyout_q <= 1'b0;
                            lat_addr    <= haddr_word;
                            lat_bank    <= haddr_bank;
                        end else begin
                            state <= ST_RD_DATA;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        sram_cs   = 4'b0000;
        SRAMWEN   = 4'b0000;
        SRAMADDR  = '0;
        SRAMWDATA = 32'h0000_0000;
        if (HRESETn) begin
            case (state)
                ST_WR_DATA: begin
                    sram_cs   = bank_onehot(lat_bank);
                    SRAMADDR  = lat_addr;
                    SRAMWEN   = lat_lanes;
                    SRAMWDATA = HWDATA;
                end
                ST_RD_STALL: begin
                    sram_cs  = bank_onehot(lat_bank);
                    SRAMADDR = lat_addr;
                end
                default: begin
                    if (rd_issue) begin
                        sram_cs  = bank_onehot(haddr_bank);
                        SRAMADDR = haddr_word;
                    end
                end
            endcase
        end
    end

    assign SRAMCS0   = sram_cs[0];
    assign SRAMCS1   = sram_cs[1];
    assign SRAMCS2   = sram_cs[2];
    assign SRAMCS3   = sram_cs[3];
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = (state == ST_RD_DATA) ? SRAMRDATA : 32'h0000_0000;

endmodule

// File: tb/tb_ahbl_sram_ctrl.sv
// tb/tb_ahbl_sram_ctrl.sv - self-checking bench for ahbl_sram_ctrl
module tb_ahbl_sram_ctrl;

    localparam int          AW    = 15;
    localparam logic [31:0] AMASK = 32'h0007_FFFF;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [31:0]   SRAMRDATA;
    logic [3:0]    SRAMWEN;
    logic [31:0]   SRAMWDATA;
    logic          SRAMCS0, SRAMCS1, SRAMCS2, SRAMCS3;
    logic [AW-1:0] SRAMADDR;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    ahbl_sram_ctrl #(.AW(AW), .RD_LAT(1)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMRDATA(SRAMRDATA),
        .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA), .SRAMCS0(SRAMCS0), .SRAMCS1(SRAMCS1),
        .SRAMCS2(SRAMCS2), .SRAMCS3(SRAMCS3), .SRAMADDR(SRAMADDR)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Four-bank synchronous SRAM with one-cycle read latency
    logic [31:0] sram [0:(1<<(AW+2))-1];
    logic [31:0] sram_rdata_q = 32'h0;
    wire  [3:0]  cs_vec = {SRAMCS3, SRAMCS2, SRAMCS1, SRAMCS0};
    assign SRAMRDATA = sram_rdata_q;

    always @(posedge HCLK) begin
        for (int b = 0; b < 4; b++) begin
            if (cs_vec[b]) begin
                if (SRAMWEN != 4'b0000) begin
                    for (int l = 0; l < 4; l++)
                        if (SRAMWEN[l]) sram[{b[1:0], SRAMADDR}][8*l +: 8] <= SRAMWDATA[8*l +: 8];
                end else begin
                    sram_rdata_q <= sram[{b[1:0], SRAMADDR}];
                end
            end
        end
    end

    typedef struct packed {
        logic [3:0]    cs;
        logic [AW-1:0] addr;
        logic [3:0]    wen;
        logic [31:0]   wdata;
    } acc_t;
    acc_t acc_log[$];

    always @(negedge HCLK) begin
        acc_t e;
        check("cs_onehot0", $onehot0(cs_vec), 1'b1);
        if (!HRESETn) check("cs_in_reset", cs_vec, 4'b0000);
        if (cs_vec != 4'b0000) begin
            e.cs = cs_vec; e.addr = SRAMADDR; e.wen = SRAMWEN; e.wdata = SRAMWDATA;
            acc_log.push_back(e);
        end
    end

    function automatic acc_t log_at(input int i);
        if (i < acc_log.size()) return acc_log[i];
        return '0;
    endfunction

    // Reference: byte-addressed memory behind the bus, aliased on the low 19 address bits
    logic [7:0] ref_mem [int];

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;
    xfer_t xq[$];

    function automatic bit is_active(input xfer_t x);
        return x.sel && x.trans[1];
    endfunction

    function automatic bit is_legal(input xfer_t x);
        if (x.size > 3'd2) return 1'b0;
        if (x.size == 3'd1) return x.addr[0] == 1'b0;
        if (x.size == 3'd2) return x.addr[1:0] == 2'b00;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        int base;
        base = int'(a & AMASK & ~32'h3);
        for (int l = 0; l < 4; l++)
            w[8*l +: 8] = ref_mem.exists(base + l) ? ref_mem[base + l] : 8'h00;
        return w;
    endfunction

    task automatic ref_write(input xfer_t x);
        logic [31:0] ba;
        int nb;
        nb = 1 << x.size;
        for (int i = 0; i < nb; i++) begin
            ba = x.addr + i;
            ref_mem[int'(ba & AMASK)] = x.wdata[8*ba[1:0] +: 8];
        end
    endtask

    task automatic push(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.write = wr; x.size = size; x.addr = addr; x.wdata = wdata;
        xq.push_back(x);
    endtask

    // Pipelined master: drains xq, checking each data phase against the reference
    task automatic run_xfers();
        xfer_t ap, dp;
        bit    ap_v, dp_v, dp_stall, err;
        int    waits;
        dp_v = 0; dp_stall = 0;
        dp = '{1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0};
        while (xq.size() > 0 || dp_v) begin
            ap_v = xq.size() > 0;
            if (ap_v) ap = xq.pop_front();
            else      ap = '{1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0};
            HSEL = ap.sel; HTRANS = ap.trans; HWRITE = ap.write; HSIZE = ap.size; HADDR = ap.addr;
            HWDATA = dp_v ? dp.wdata : 32'h0;
            err = dp_v && is_active(dp) && !is_legal(dp);
            waits = 0;
            @(negedge HCLK);
            while (HREADYOUT !== 1'b1 && waits < 4) begin
                waits++;
                check("wait_resp", HRESP, err);
                @(negedge HCLK);
            end
            if (HREADYOUT !== 1'b1) check("ready_timeout", HREADYOUT, 1'b1);
            if (dp_v) begin
                check("waits", waits, (err || dp_stall) ? 1 : 0);
                check("resp", HRESP, err);
                if (is_active(dp) && !err && !dp.write) check("rdata", HRDATA, ref_word(dp.addr));
                else                                     check("rdata_zero", HRDATA, 32'h0);
                if (is_active(dp) && !err && dp.write) ref_write(dp);
            end
            @(posedge HCLK); #1;
            dp_stall = ap_v && is_active(ap) && is_legal(ap) && !ap.write &&
                       dp_v && is_active(dp) && is_legal(dp) && dp.write;
            dp = ap; dp_v = ap_v;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails + 1);
        $fatal(1);
    end

    initial begin
        acc_t  e;
        logic [2:0]  sz;
        logic [31:0] a;
        int          r;
        for (int i = 0; i < (1 << (AW+2)); i++) sram[i] = 32'h0;
        HRESETn = 1'b0; HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HSIZE = 0; HWDATA = 0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_ready", HREADYOUT, 1'b1);
        check("rst_resp", HRESP, 1'b0);
        check("rst_rdata", HRDATA, 32'h0);
        check("rst_wen", SRAMWEN, 4'h0);
        check("rst_addr", SRAMADDR, 15'h0);
        check("rst_wdata", SRAMWDATA, 32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Write then read of the same word: read stalls one cycle behind the write
        acc_log.delete();
        push(1, 2'b10, 1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF);
        push(1, 2'b10, 0, 3'd2, 32'h0000_0010, 32'h0);
        run_xfers();
        check("t2_nacc", acc_log.size(), 2);
        e = log_at(0);
        check("t2_wr", {e.cs, e.addr, e.wen}, {4'b0001, 15'd4, 4'hF});
        check("t2_wdata", e.wdata, 32'hDEAD_BEEF);
        e = log_at(1);
        check("t2_rd", {e.cs, e.addr, e.wen}, {4'b0001, 15'd4, 4'h0});

        // Byte and halfword writes into bank 1, then a word read after an idle
        acc_log.delete();
        push(1, 2'b10, 1, 3'd0, 32'h0002_0003, 32'hAB00_0000);
        push(1, 2'b10, 1, 3'd1, 32'h0002_0000, 32'h0000_1234);
        push(1, 2'b00, 0, 3'd0, 32'h0, 32'h0);
        push(1, 2'b10, 0, 3'd2, 32'h0002_0000, 32'h0);
        run_xfers();
        check("t3_nacc", acc_log.size(), 3);
        e = log_at(0);
        check("t3_byte", {e.cs, e.addr, e.wen}, {4'b0010, 15'd0, 4'b1000});
        e = log_at(1);
        check("t3_half", {e.cs, e.addr, e.wen}, {4'b0010, 15'd0, 4'b0011});
        check("t3_word", {ref_word(32'h0002_0000) & 32'hFF00_FFFF}, 32'hAB00_1234);

        // Back-to-back reads in address order
        push(1, 2'b10, 1, 3'd2, 32'h0, $urandom);
        push(1, 2'b11, 1, 3'd2, 32'h4, $urandom);
        push(1, 2'b11, 1, 3'd2, 32'h8, $urandom);
        run_xfers();
        acc_log.delete();
        push(1, 2'b10, 0, 3'd2, 32'h0, 32'h0);
        push(1, 2'b11, 0, 3'd2, 32'h4, 32'h0);
        push(1, 2'b11, 0, 3'd2, 32'h8, 32'h0);
        run_xfers();
        check("t4_nacc", acc_log.size(), 3);
        for (int i = 0; i < 3; i++) begin
            e = log_at(i);
            check("t4_rd", {e.cs, e.addr, e.wen}, {4'b0001, 15'(i), 4'h0});
        end

        // Illegal size/alignment: ERROR, no SRAM activity
        acc_log.delete();
        push(1, 2'b10, 0, 3'd2, 32'h0000_0002, 32'h0);
        push(1, 2'b10, 0, 3'd3, 32'h0000_0000, 32'h0);
        push(1, 2'b10, 1, 3'd1, 32'h0000_0001, 32'hFFFF_FFFF);
        run_xfers();
        check("t5_nacc", acc_log.size(), 0);

        // Bank 3 write then idle and deselected traffic: a single CS3 pulse
        acc_log.delete();
        push(1, 2'b10, 1, 3'd0, 32'h0006_0005, 32'h0000_5500);
        push(1, 2'b00, 0, 3'd0, 32'h0, 32'h0);
        push(0, 2'b10, 1, 3'd2, 32'h0006_0000, 32'h1111_1111);
        push(0, 2'b10, 0, 3'd2, 32'h0006_0004, 32'h0);
        push(0, 2'b11, 0, 3'd2, 32'h0000_0000, 32'h0);
        run_xfers();
        check("t6_nacc", acc_log.size(), 1);
        e = log_at(0);
        check("t6_wr", {e.cs, e.addr, e.wen}, {4'b1000, 15'd1, 4'b0010});

        // Reset in the middle of a write data phase
        push(1, 2'b10, 1, 3'd2, 32'h0000_0040, 32'h1122_3344);
        run_xfers();
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HSIZE = 3'd2; HADDR = 32'h0000_0040;
        @(posedge HCLK); #1;
        HTRANS = 2'b00; HWRITE = 0; HWDATA = 32'hCAFE_F00D;
        #2; HRESETn = 1'b0; #1;
        check("mid_rst_cs", cs_vec, 4'b0000);
        check("mid_rst_wen", SRAMWEN, 4'h0);
        check("mid_rst_ready", HREADYOUT, 1'b1);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        check("mid_rst_sram", sram[16], 32'h1122_3344);
        push(1, 2'b10, 0, 3'd2, 32'h0000_0040, 32'h0);
        run_xfers();

        // Randomized traffic with aliased upper address bits
        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 9);
            sz = (r <= 2) ? 3'(r) : ((r <= 7) ? 3'd2 : 3'(r - 5));
            a  = $urandom;
            a[16:6] = '0;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            push($urandom_range(0, 9) != 0, ($urandom_range(0, 9) < 7) ? 2'(2 + $urandom_range(0, 1))
                                                                        : 2'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), sz, a, $urandom);
        end
        run_xfers();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ahbl_sram_ctrl.md
Name: ahbl_sram_ctrl

Overview:
- AHB-lite slave (responder) that serves the IBEX master's transfers from the four-bank synchronous single-port SoC SRAM.
- Drives the SRAMCS0..3, SRAMWEN, SRAMADDR and SRAMWDATA interface and returns SRAMRDATA on HRDATA.
- Sits on one system-bus slave port.
- Zero-wait reads and writes; one wait state on a read-after-write port collision; ERROR response for illegal size or alignment.

Parameters:
- AW, 15, SRAM word-address width per bank; the bank is selected by HADDR[AW+3:AW+2].
- RD_LAT, 1, SRAM read latency in cycles. Only 1 is supported; any other value is rejected at elaboration.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus ready (previous transfer done)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  1 = ERROR
- HRDATA  out  32  read data
- SRAMRDATA  in  32  SRAM read data, valid the cycle after a read enable
- SRAMWEN  out  4  byte write enables
- SRAMWDATA  out  32  SRAM write data
- SRAMCS0, SRAMCS1, SRAMCS2, SRAMCS3  out  1 each  bank chip selects (one-hot or all 0)
- SRAMADDR  out  AW  word address

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is asynchronous, active-low.
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, all CS=0, SRAMWEN=0, SRAMADDR=0, SRAMWDATA=0. Any pending write or read is discarded; no SRAM access occurs while HRESETn=0.
- Accept condition: accept = HSEL & HTRANS[1] & HREADY. IDLE and BUSY transfers get an OKAY response with zero wait.
- Lanes:
  - HSIZE=0: lane HADDR[1:0].
  - HSIZE=1: lanes {HADDR[1],0} and {HADDR[1],1}.
  - HSIZE=2: all four lanes.
- Illegal transfer (HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0): no SRAM access. Two-cycle ERROR: cycle 1 HREADYOUT=0/HRESP=1, cycle 2 HREADYOUT=1/HRESP=1.
- State machine states: IDLE, WR_DATA, RD_DATA, RD_STALL, ERR1, ERR2.
- Read accepted in IDLE, RD_DATA or ERR2:
  - In the same (address-phase) cycle, SRAMADDR=HADDR[AW+1:2] and the bank CS is driven combinationally, SRAMWEN=0.
  - Next state RD_DATA: HRDATA=SRAMRDATA, HREADYOUT=1 (zero wait).
- Write accepted:
  - Latch address, bank and lanes; next state WR_DATA.
  - In WR_DATA, drive CS, SRAMADDR (latched), SRAMWEN=lanes and SRAMWDATA=HWDATA. HREADYOUT=1.
  - Back-to-back writes have no wait: the new address is latched while the previous one is written.
- Read accepted during WR_DATA (port busy):
  - Latch the read address; next state RD_STALL.
  - In RD_STALL: HREADYOUT=0, SRAM read issued with the latched address; next state RD_DATA, where data is returned.
  - The master holds its next address during RD_STALL; no accept occurs.
- HRDATA=0 in every state except RD_DATA.
- Outside an active access: CS all 0, SRAMWEN=0.
- Bank field: HADDR[AW+3:AW+2]=b selects SRAMCSb only. Address bits above AW+3 are ignored (the system decoder owns the map).
- Idle after a write returns to IDLE. An ERROR-triggering transfer accepted during WR_DATA still lets the pending write complete.

Decomposition:
- Shared package ahbl_pkg:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ)
  - HSIZE codes (BYTE/HALF/WORD)
  - HRESP codes (OKAY/ERROR)
  - controller state enum
- Sub-module ahbl_lane_dec: combinational {HSIZE, HADDR[1:0]} -> 4-bit lane mask plus illegal flag. Reused by other AHB slaves.

Test Plan:
- Reset: assert HRESETn=0 mid-WR_DATA -> CS=0, WEN=0, HREADYOUT=1 immediately; SRAM word unchanged.
- Word write 0xDEADBEEF to 0x0000_0010, then word read of the same address -> write has zero wait, SRAMADDR=4, WEN=4'hF, CS0=1. Read is issued during the write's data phase, so one RD_STALL cycle (HREADYOUT=0), then HRDATA=0xDEADBEEF.
- Byte write 0xAB to 0x0002_0003 (bank 1, AW=15) then halfword write 0x1234 to 0x0002_0000 -> WEN=4'b1000 with CS1, then WEN=4'b0011. Word read after one IDLE cycle returns 0xAB??1234, zero wait.
- Back-to-back reads at 0x00, 0x04, 0x08 (NONSEQ/SEQ) -> three consecutive data phases, HREADYOUT=1 throughout, data in address order.
- Word read at 0x0000_0002 or HSIZE=3 -> HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; CS stays 0 throughout.
- Write 0x55 at bank 3 followed by an IDLE transfer and then HSEL=0 traffic -> only SRAMCS3 pulses, once; no further CS activity.
